// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the FIFO entry layout for alu_op_queue.
// ALU_FWD_EN adds a per-entry forwarding flag to the entry layout.
package alu_pkg;

  localparam int unsigned ALU_W = 32;
  localparam int unsigned OP_W  = 3;

  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [OP_W-1:0] ALU_SRL = 3'b100;
  localparam logic [OP_W-1:0] ALU_SRA = 3'b101;
  localparam logic [OP_W-1:0] ALU_GTU = 3'b110;
  localparam logic [OP_W-1:0] ALU_SGT = 3'b111;

  typedef struct packed {
`ifdef ALU_FWD_EN
    logic              fwd;
`endif
    logic [ALU_W-1:0]  a;
    logic [ALU_W-1:0]  b;
    logic [OP_W-1:0]   op;
  } alu_entry_t;

  localparam int unsigned ENTRY_W = $bits(alu_entry_t);

endpackage

// File: rtl/alu_fifo.sv
// Generic DEPTH x W synchronous FIFO with occupancy count and async active-low reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 67,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only entries between the pointers are ever meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_op_queue.sv
// Buffered ALU issue stage: op FIFO feeding the ALU, with a registered valid/ready result.
// Define ALU_FWD_EN to let an op take the previous result as its A operand.
module alu_op_queue
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ALU_W-1:0]  in_a,
  input  logic [ALU_W-1:0]  in_b,
  input  logic [OP_W-1:0]   in_op,
  input  logic              in_fwd,
  output logic [ALU_W-1:0]  alu_a,
  output logic [ALU_W-1:0]  alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [ALU_W-1:0]  alu_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ALU_W-1:0]  res_data,
  output logic [AW:0]       count
);

  alu_entry_t       wr_entry, head;
  logic             fifo_full, fifo_empty;
  logic             push, issue;
  logic             res_valid_q, res_valid_d;
  logic [ALU_W-1:0] res_data_q, res_data_d;

  always_comb begin
    wr_entry    = '0;
    wr_entry.a  = in_a;
    wr_entry.b  = in_b;
    wr_entry.op = in_op;
`ifdef ALU_FWD_EN
    wr_entry.fwd = in_fwd;
`endif
  end

  alu_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (issue),
    .wdata (wr_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;
  // Issue whenever the output register is free or is being drained this cycle.
  assign issue    = ~fifo_empty & (~res_valid_q | res_ready);

  assign alu_b  = head.b;
  assign alu_op = head.op;

`ifdef ALU_FWD_EN
  logic [ALU_W-1:0] last_c_q, last_c_d;

  assign alu_a    = head.fwd ? last_c_q : head.a;
  assign last_c_d = issue ? alu_c : last_c_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_c_q <= '0;
    else        last_c_q <= last_c_d;
  end
`else
  logic unused_in_fwd;

  assign alu_a         = head.a;
  assign unused_in_fwd = in_fwd;
`endif

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    if (issue) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_c;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule
